// File: rtl/tile_write_arbiter.sv
// tile_write_arbiter: sole writer of the 6x8 tile array; frame-aligned level
// load plus gift/edit tile arbitration. Optional counter: TILE_GIFT_COUNT_EN.
module tile_write_arbiter #(
    parameter int NUM_COLS = 8,
    parameter int NUM_ROWS = 6,
    parameter int LEVELS   = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       StartOfFrame,
    input  logic                       load_req,
    input  logic [$clog2(LEVELS)-1:0]  load_level,
    output logic                       load_busy,
    output logic                       load_done,
    output logic [7:0]                 rom_addr,
    input  logic [1:0]                 rom_data,
    input  logic                       giftReq,
    input  logic [2:0]                 giftX,
    input  logic [2:0]                 giftY,
    output logic                       giftAck,
    input  logic                       editReq,
    input  logic [2:0]                 editX,
    input  logic [2:0]                 editY,
    input  logic [1:0]                 editInfo,
    output logic                       editAck,
`ifdef TILE_GIFT_COUNT_EN
    output logic [5:0]                 gifts_left,
    output logic                       all_gifts_cleared,
`endif
    output logic                       writeEn,
    output logic [2:0]                 TargetX,
    output logic [2:0]                 TargetY,
    output logic [1:0]                 information
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD} state_t;

    localparam logic [3:0] LP_COLS  = 4'(NUM_COLS);
    localparam logic [3:0] LP_ROWS  = 4'(NUM_ROWS);
    localparam logic [5:0] LP_TILES = 6'(NUM_COLS * NUM_ROWS);

    state_t                      r_state;
    logic [$clog2(LEVELS)-1:0]   r_level;
    logic [5:0]                  r_index;
    logic [2:0]                  r_x;
    logic [2:0]                  r_y;
    logic                        r_v1;
    logic [2:0]                  r_x1;
    logic [2:0]                  r_y1;

    logic w_serve;
    logic w_gift_go;
    logic w_edit_go;
    logic w_gift_in;
    logic w_edit_in;

    // A requester whose ack is showing is ignored for that cycle.
    assign w_serve   = (r_state == S_IDLE && !load_req) || (r_state == S_WAIT);
    assign w_gift_go = giftReq && !giftAck;
    assign w_edit_go = editReq && !editAck && !w_gift_go;
    assign w_gift_in = ({1'b0, giftX} < LP_COLS) && ({1'b0, giftY} < LP_ROWS);
    assign w_edit_in = ({1'b0, editX} < LP_COLS) && ({1'b0, editY} < LP_ROWS);

    assign rom_addr = (r_state == S_LOAD && r_index < LP_TILES)
                    ? 8'(r_level) * 8'(NUM_COLS * NUM_ROWS) + 8'(r_index)
                    : 8'd0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_level     <= '0;
            r_index     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_v1        <= 1'b0;
            r_x1        <= '0;
            r_y1        <= '0;
            load_busy   <= 1'b0;
            load_done   <= 1'b0;
            giftAck     <= 1'b0;
            editAck     <= 1'b0;
            writeEn     <= 1'b0;
            TargetX     <= '0;
            TargetY     <= '0;
            information <= '0;
        end else begin
            load_done <= 1'b0;
            giftAck   <= 1'b0;
            editAck   <= 1'b0;
            writeEn   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (load_req) begin
                        r_level   <= load_level;
                        load_busy <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (load_req)
                        r_level <= load_level;
                    if (StartOfFrame) begin
                        r_state <= S_LOAD;
                        r_index <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_v1    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // ROM answers one cycle after the address, so the
                    // coordinates ride a one-stage pipe alongside it.
                    r_v1    <= (r_index < LP_TILES);
                    r_x1    <= r_x;
                    r_y1    <= r_y;
                    r_index <= r_index + 6'd1;
                    if ({1'b0, r_x} == LP_COLS - 4'd1) begin
                        r_x <= '0;
                        r_y <= r_y + 3'd1;
                    end else begin
                        r_x <= r_x + 3'd1;
                    end
                    if (r_v1) begin
                        writeEn     <= 1'b1;
                        TargetX     <= r_x1;
                        TargetY     <= r_y1;
                        information <= rom_data;
                    end
                    if (r_index == LP_TILES + 6'd1) begin
                        r_state   <= S_IDLE;
                        load_busy <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_serve) begin
                if (w_gift_go) begin
                    giftAck <= 1'b1;
                    if (w_gift_in) begin
                        writeEn     <= 1'b1;
                        TargetX     <= giftX;
                        TargetY     <= giftY;
                        information <= 2'b00;
                    end
                end else if (w_edit_go) begin
                    editAck <= 1'b1;
                    if (w_edit_in) begin
                        writeEn     <= 1'b1;
                        TargetX     <= editX;
                        TargetY     <= editY;
                        information <= editInfo;
                    end
                end
            end
        end
    end

`ifdef TILE_GIFT_COUNT_EN
    logic w_sof_go;
    logic w_ld_gift;
    logic w_gift_wr;
    logic w_edit_gift;

    assign w_sof_go    = (r_state == S_WAIT) && StartOfFrame;
    assign w_ld_gift   = (r_state == S_LOAD) && r_v1 && (rom_data == 2'b10);
    assign w_gift_wr   = w_serve && w_gift_go && w_gift_in;
    assign w_edit_gift = w_serve && w_edit_go && w_edit_in
                       && (editInfo == 2'b10);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gifts_left        <= '0;
            all_gifts_cleared <= 1'b0;
        end else begin
            all_gifts_cleared <= (gifts_left == 6'd0) && !load_busy;
            if (w_sof_go)
                gifts_left <= '0;
            else if ((w_ld_gift || w_edit_gift) && gifts_left != 6'h3f)
                gifts_left <= gifts_left + 6'd1;
            else if (w_gift_wr && gifts_left != 6'd0)
                gifts_left <= gifts_left - 6'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_write_arbiter.sv
// Directed self-checking bench for tile_write_arbiter with a synchronous
// level-ROM model; gift-counter checks compile in with TILE_GIFT_COUNT_EN.
module tb_tile_write_arbiter;

    logic       clk;
    logic       resetN;
    logic       StartOfFrame;
    logic       load_req;
    logic [1:0] load_level;
    logic       load_busy;
    logic       load_done;
    logic [7:0] rom_addr;
    logic [1:0] rom_data;
    logic       giftReq;
    logic [2:0] giftX;
    logic [2:0] giftY;
    logic       giftAck;
    logic       editReq;
    logic [2:0] editX;
    logic [2:0] editY;
    logic [1:0] editInfo;
    logic       editAck;
    logic       writeEn;
    logic [2:0] TargetX;
    logic [2:0] TargetY;
    logic [1:0] information;
`ifdef TILE_GIFT_COUNT_EN
    logic [5:0] gifts_left;
    logic       all_gifts_cleared;
`endif

    logic [1:0] rom [256];
    int checks = 0;
    int failures = 0;

    tile_write_arbiter dut (
        .clk(clk),
        .resetN(resetN),
        .StartOfFrame(StartOfFrame),
        .load_req(load_req),
        .load_level(load_level),
        .load_busy(load_busy),
        .load_done(load_done),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .giftReq(giftReq),
        .giftX(giftX),
        .giftY(giftY),
        .giftAck(giftAck),
        .editReq(editReq),
        .editX(editX),
        .editY(editY),
        .editInfo(editInfo),
        .editAck(editAck),
`ifdef TILE_GIFT_COUNT_EN
        .gifts_left(gifts_left),
        .all_gifts_cleared(all_gifts_cleared),
`endif
        .writeEn(writeEn),
        .TargetX(TargetX),
        .TargetY(TargetY),
        .information(information)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input int lvl, input bit hold_gift);
        load_req = 1'b1;
        load_level = 2'(lvl);
        tick();
        load_req = 1'b0;
        chk("busy_accept", load_busy, 1);
        chk("addr_wait", rom_addr, 0);
        StartOfFrame = 1'b1;
        tick();
        StartOfFrame = 1'b0;
        if (hold_gift) begin
            giftReq = 1'b1;
            giftX = 3'd5;
            giftY = 3'd3;
        end
        for (int t = 0; t <= 50; t++) begin
            if (t > 0) tick();
            if (t <= 47) chk("rom_addr", rom_addr, lvl * 48 + t);
            chk("we_load", writeEn, (t >= 2 && t <= 49));
            if (t >= 2 && t <= 49) begin
                chk("load_x", TargetX, (t - 2) % 8);
                chk("load_y", TargetY, (t - 2) / 8);
                chk("load_info", information, rom[lvl * 48 + t - 2]);
            end
            chk("load_done", load_done, (t == 50));
            chk("load_busy", load_busy, (t < 50));
            chk("gack_in_load", giftAck, 0);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++)
            rom[a] = (a >= 96 && a < 144) ? 2'b00 : 2'(a % 4);
        rom[100] = 2'b10;
        rom[120] = 2'b10;
        rom[143] = 2'b10;

        resetN = 1'b0;
        StartOfFrame = 1'b0;
        load_req = 1'b0;
        load_level = 2'd0;
        giftReq = 1'b0;
        giftX = 3'd0;
        giftY = 3'd0;
        editReq = 1'b0;
        editX = 3'd0;
        editY = 3'd0;
        editInfo = 2'd0;
        tick();
        chk("rst_we", writeEn, 0);
        chk("rst_busy", load_busy, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_xy", {TargetX, TargetY, information}, 0);
        resetN = 1'b1;
        tick();

        do_load(1, 1'b0);

        giftReq = 1'b1;
        giftX = 3'd3;
        giftY = 3'd2;
        tick();
        chk("gift_we", writeEn, 1);
        chk("gift_x", TargetX, 3);
        chk("gift_y", TargetY, 2);
        chk("gift_info", information, 0);
        chk("gift_ack", giftAck, 1);
        tick();
        chk("gift_spacing_we", writeEn, 0);
        chk("gift_spacing_ack", giftAck, 0);
        giftReq = 1'b0;
        tick();

        giftReq = 1'b1;
        giftX = 3'd1;
        giftY = 3'd1;
        editReq = 1'b1;
        editX = 3'd4;
        editY = 3'd4;
        editInfo = 2'b01;
        tick();
        chk("both_g_we", writeEn, 1);
        chk("both_g_xy", {TargetX, TargetY}, {3'd1, 3'd1});
        chk("both_g_acks", {giftAck, editAck}, 2'b10);
        giftReq = 1'b0;
        tick();
        chk("both_e_we", writeEn, 1);
        chk("both_e_xy", {TargetX, TargetY}, {3'd4, 3'd4});
        chk("both_e_info", information, 1);
        chk("both_e_acks", {giftAck, editAck}, 2'b01);
        editReq = 1'b0;
        tick();
        chk("both_idle_we", writeEn, 0);

        do_load(0, 1'b1);
        tick();
        chk("held_gift_ack", giftAck, 1);
        chk("held_gift_we", writeEn, 1);
        chk("held_gift_xy", {TargetX, TargetY}, {3'd5, 3'd3});
        giftReq = 1'b0;
        tick();

        editReq = 1'b1;
        editX = 3'd7;
        editY = 3'd6;
        editInfo = 2'b11;
        tick();
        chk("oor_ack", editAck, 1);
        chk("oor_we", writeEn, 0);
        editReq = 1'b0;
        tick();

        load_req = 1'b1;
        load_level = 2'd3;
        tick();
        load_req = 1'b0;
        StartOfFrame = 1'b1;
        tick();
        StartOfFrame = 1'b0;
        for (int t = 1; t <= 20; t++) tick();
        chk("mid_addr", rom_addr, 164);
        resetN = 1'b0;
        #1;
        chk("mid_rst_we", writeEn, 0);
        chk("mid_rst_addr", rom_addr, 0);
        chk("mid_rst_busy", {load_busy, load_done, giftAck, editAck}, 0);
        chk("mid_rst_data", {TargetX, TargetY, information}, 0);
        tick();
        resetN = 1'b1;
        tick();

        do_load(2, 1'b0);
`ifdef TILE_GIFT_COUNT_EN
        chk("gifts_after_load", gifts_left, 3);
        tick();
        chk("not_cleared", all_gifts_cleared, 0);
        for (int g = 0; g < 3; g++) begin
            giftReq = 1'b1;
            giftX = 3'(g);
            giftY = 3'd2;
            tick();
            giftReq = 1'b0;
            tick();
        end
        chk("gifts_zero", gifts_left, 0);
        chk("all_cleared", all_gifts_cleared, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
